// File: rtl/resp_misr.sv
// resp_misr: folds a wide response bus into a SIG_W-bit chunk XOR every valid beat and
// compacts CYCLES beats into a multiple-input signature register with a valid/ready handoff.
module resp_misr #(
   parameter int                WIDTH  = 481,
   parameter int                SIG_W  = 32,
   parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
   parameter logic [SIG_W-1:0]  SEED   = 32'hFFFFFFFF,
   parameter int                CYCLES = 21,
   localparam int               CNT_W  = $clog2(CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] y_in,
   input  logic             y_valid,
   output logic [SIG_W-1:0] sig_out,
   output logic             sig_valid,
   input  logic             sig_ready,
   output logic             busy,
   output logic [CNT_W-1:0] beat_cnt
);

   localparam int               NCHUNK    = (WIDTH + SIG_W - 1) / SIG_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [SIG_W-1:0] sig_q;
   logic [CNT_W-1:0] cnt_q;
   logic             load, absorb;

   // Zero-padded top chunk falls out of clearing the padded vector first.
   function automatic logic [SIG_W-1:0] fold_chunks(input logic [WIDTH-1:0] y);
      logic [NCHUNK*SIG_W-1:0] padded;
      logic [SIG_W-1:0]        acc;
      padded            = '0;
      padded[WIDTH-1:0] = y;
      acc               = '0;
      for (int i = 0; i < NCHUNK; i++) acc ^= padded[i*SIG_W +: SIG_W];
      return acc;
   endfunction

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                  input logic [SIG_W-1:0] f);
      return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ f;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (y_valid && cnt_q == LAST_BEAT) state_d = DONE;
         DONE:    if (sig_ready) state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A restart is only honoured from IDLE or on the DONE handshake cycle.
   always_comb begin
      busy      = (state_q == RUN);
      sig_valid = (state_q == DONE);
      load      = start && ((state_q == IDLE) || (state_q == DONE && sig_ready));
      absorb    = (state_q == RUN) && y_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sig_q <= SEED;
         cnt_q <= '0;
      end else if (absorb) begin
         sig_q <= misr_step(sig_q, fold_chunks(y_in));
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign sig_out  = sig_q;
   assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_resp_misr.sv
// Randomised bench for resp_misr: two instances (CYCLES=21 and CYCLES=1) checked against
// a bit-level reference model of the fold and signature recurrence.
module tb_resp_misr;

   localparam int          W    = 481;
   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;

   logic         clk = 1'b0;
   logic         rst_n, start21, start1, y_valid, sig_ready;
   logic [W-1:0] y_in;
   logic [31:0]  sig21, sig1;
   logic         sv21, sv1, busy21, busy1;
   logic [4:0]   cnt21;
   logic [0:0]   cnt1;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] model_q[$];

   always #5 clk = ~clk;

   resp_misr #(.CYCLES(21)) dut21 (
      .clk(clk), .rst_n(rst_n), .start(start21), .y_in(y_in), .y_valid(y_valid),
      .sig_out(sig21), .sig_valid(sv21), .sig_ready(sig_ready), .busy(busy21),
      .beat_cnt(cnt21));

   resp_misr #(.CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y_in), .y_valid(y_valid),
      .sig_out(sig1), .sig_valid(sv1), .sig_ready(sig_ready), .busy(busy1),
      .beat_cnt(cnt1));

   // Bit j of the bus lands on fold bit j mod 32.
   function automatic logic [31:0] ref_fold(input logic [W-1:0] y);
      logic [31:0] f = '0;
      for (int j = 0; j < W; j++) f[j % 32] = f[j % 32] ^ y[j];
      return f;
   endfunction

   function automatic logic [31:0] ref_sig();
      logic [31:0] s = SEED;
      foreach (model_q[k]) s = ((s << 1) ^ (s[31] ? POLY : 32'h0)) ^ ref_fold(model_q[k]);
      return s;
   endfunction

   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = 1'($urandom);
      return v;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start21 = 1'b0; start1 = 1'b0; y_valid = 1'b0; sig_ready = 1'b0; y_in = '0;
      repeat (2) cyc();
      checks++;
      if ({sig21, sv21, busy21, cnt21} !== '0) begin
         errors++;
         $display("FAIL reset21 got sig=%h v=%b busy=%b cnt=%0d want all zero", sig21, sv21, busy21, cnt21);
      end
      checks++;
      if ({sig1, sv1, busy1, cnt1} !== '0) begin
         errors++;
         $display("FAIL reset1 got sig=%h v=%b busy=%b cnt=%0d want all zero", sig1, sv1, busy1, cnt1);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_mid_run_reset();
      start21 = 1'b1; cyc(); start21 = 1'b0;
      checks++;
      if (busy21 !== 1'b1 || sig21 !== SEED) begin
         errors++;
         $display("FAIL start_load got busy=%b sig=%h want 1 %h", busy21, sig21, SEED);
      end
      for (int i = 0; i < 5; i++) begin
         y_in = rand_beat(); y_valid = 1'b1; cyc();
      end
      y_valid = 1'b0;
      checks++;
      if (cnt21 !== 5'd5) begin
         errors++;
         $display("FAIL five_beats got cnt=%0d want 5", cnt21);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sig21, sv21, busy21, cnt21} !== '0) begin
         errors++;
         $display("FAIL async_reset got sig=%h v=%b busy=%b cnt=%0d want all zero", sig21, sv21, busy21, cnt21);
      end
      cyc(); rst_n = 1'b1;
      y_in = rand_beat(); y_valid = 1'b1; cyc(); cyc(); y_valid = 1'b0;
      checks++;
      if (busy21 !== 1'b0 || cnt21 !== 5'd0) begin
         errors++;
         $display("FAIL no_auto_restart got busy=%b cnt=%0d want 0 0", busy21, cnt21);
      end
      start1 = 1'b1; cyc(); start1 = 1'b0;
      y_in = '0; y_valid = 1'b1; cyc(); y_valid = 1'b0;
      checks++;
      if (sv1 !== 1'b1 || sig1 !== 32'hFB3EE249) begin
         errors++;
         $display("FAIL post_reset_run got v=%b sig=%h want 1 fb3ee249", sv1, sig1);
      end
      sig_ready = 1'b1; cyc(); sig_ready = 1'b0;
      checks++;
      if (sv1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL handshake1 got v=%b busy=%b want 0 0", sv1, busy1);
      end
   endtask

   task automatic test_c1_ones();
      start1 = 1'b1; cyc(); start1 = 1'b0;
      y_in = '1; y_valid = 1'b1; cyc(); y_valid = 1'b0;
      checks++;
      if (sv1 !== 1'b1 || busy1 !== 1'b0 || sig1 !== 32'h04C11DB7 || cnt1 !== 1'b1) begin
         errors++;
         $display("FAIL ones_beat got v=%b busy=%b sig=%h cnt=%0d want 1 0 04c11db7 1", sv1, busy1, sig1, cnt1);
      end
      sig_ready = 1'b1; cyc(); sig_ready = 1'b0;
   endtask

   task automatic test_c1_zero_hold();
      start1 = 1'b1; cyc(); start1 = 1'b0;
      y_in = '0; y_valid = 1'b1; cyc();
      for (int i = 0; i < 10; i++) begin
         y_in = rand_beat(); y_valid = 1'($urandom);
         cyc();
         checks++;
         if (sv1 !== 1'b1 || sig1 !== 32'hFB3EE249) begin
            errors++;
            $display("FAIL hold_cycle%0d got v=%b sig=%h want 1 fb3ee249", i, sv1, sig1);
         end
      end
      y_valid = 1'b0;
      sig_ready = 1'b1; cyc(); sig_ready = 1'b0;
   endtask

   task automatic test_toggle_valid();
      int exp_cnt = 0;
      model_q.delete();
      start21 = 1'b1; cyc(); start21 = 1'b0;
      for (int i = 0; i < 41; i++) begin
         y_in = rand_beat(); y_valid = (i % 2 == 0);
         if (y_valid) begin model_q.push_back(y_in); exp_cnt++; end
         cyc();
         checks++;
         if (cnt21 !== 5'(exp_cnt) || busy21 !== (exp_cnt < 21) || sv21 !== (exp_cnt == 21)) begin
            errors++;
            $display("FAIL toggle_cyc%0d got cnt=%0d busy=%b v=%b want %0d %b %b", i, cnt21, busy21,
                     sv21, exp_cnt, exp_cnt < 21, exp_cnt == 21);
         end
      end
      y_valid = 1'b0;
      checks++;
      if (sig21 !== ref_sig()) begin
         errors++;
         $display("FAIL toggle_sig got %h want %h", sig21, ref_sig());
      end
      cyc();
      checks++;
      if (cnt21 !== 5'd21 || sv21 !== 1'b1) begin
         errors++;
         $display("FAIL done_saturate got cnt=%0d v=%b want 21 1", cnt21, sv21);
      end
      sig_ready = 1'b1; cyc(); sig_ready = 1'b0;
      checks++;
      if (sv21 !== 1'b0 || busy21 !== 1'b0 || cnt21 !== 5'd21) begin
         errors++;
         $display("FAIL toggle_release got v=%b busy=%b cnt=%0d want 0 0 21", sv21, busy21, cnt21);
      end
   endtask

   task automatic test_start_in_run();
      model_q.delete();
      start21 = 1'b1; cyc(); start21 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         y_in = rand_beat(); y_valid = 1'b1; model_q.push_back(y_in); cyc();
      end
      start21 = 1'b1; y_valid = 1'b0; cyc();
      checks++;
      if (cnt21 !== 5'd3 || sig21 !== ref_sig() || busy21 !== 1'b1) begin
         errors++;
         $display("FAIL start_run_idle got cnt=%0d sig=%h want 3 %h", cnt21, sig21, ref_sig());
      end
      y_in = rand_beat(); y_valid = 1'b1; model_q.push_back(y_in); cyc();
      start21 = 1'b0;
      checks++;
      if (cnt21 !== 5'd4 || sig21 !== ref_sig()) begin
         errors++;
         $display("FAIL start_run_beat got cnt=%0d sig=%h want 4 %h", cnt21, sig21, ref_sig());
      end
      for (int i = 4; i < 21; i++) begin
         y_in = rand_beat(); model_q.push_back(y_in); cyc();
      end
      y_valid = 1'b0;
      checks++;
      if (sv21 !== 1'b1 || sig21 !== ref_sig()) begin
         errors++;
         $display("FAIL start_run_final got v=%b sig=%h want 1 %h", sv21, sig21, ref_sig());
      end
      sig_ready = 1'b1; start21 = 1'b1; cyc(); sig_ready = 1'b0; start21 = 1'b0;
      checks++;
      if (busy21 !== 1'b1 || sv21 !== 1'b0 || sig21 !== SEED || cnt21 !== 5'd0) begin
         errors++;
         $display("FAIL restart_handshake got busy=%b v=%b sig=%h cnt=%0d want 1 0 %h 0", busy21, sv21,
                  sig21, cnt21, SEED);
      end
      model_q.delete();
      for (int i = 0; i < 21; i++) begin
         y_in = rand_beat(); y_valid = 1'b1; model_q.push_back(y_in); cyc();
      end
      y_valid = 1'b0;
      checks++;
      if (sv21 !== 1'b1 || sig21 !== ref_sig()) begin
         errors++;
         $display("FAIL restarted_run got v=%b sig=%h want 1 %h", sv21, sig21, ref_sig());
      end
      sig_ready = 1'b1; cyc(); sig_ready = 1'b0;
   endtask

   task automatic test_flip();
      logic [W-1:0] beats[21];
      logic [31:0]  got[2];
      int           fb, fi;
      for (int i = 0; i < 21; i++) beats[i] = rand_beat();
      fb = $urandom_range(0, 20); fi = $urandom_range(0, W - 1);
      for (int p = 0; p < 2; p++) begin
         if (p == 1) beats[fb][fi] = ~beats[fb][fi];
         model_q.delete();
         start21 = 1'b1; cyc(); start21 = 1'b0;
         for (int i = 0; i < 21; i++) begin
            y_in = beats[i]; y_valid = 1'b1; model_q.push_back(y_in); cyc();
         end
         y_valid = 1'b0;
         got[p] = sig21;
         checks++;
         if (sv21 !== 1'b1 || sig21 !== ref_sig()) begin
            errors++;
            $display("FAIL flip_pass%0d got v=%b sig=%h want 1 %h", p, sv21, sig21, ref_sig());
         end
         sig_ready = 1'b1; cyc(); sig_ready = 1'b0;
      end
      checks++;
      if (got[0] === got[1]) begin
         errors++;
         $display("FAIL flip_differs got %h and %h want distinct (beat %0d bit %0d)", got[0], got[1], fb, fi);
      end
   endtask

   task automatic test_back_to_back();
      int n, guard;
      start21 = 1'b1; cyc(); start21 = 1'b0;
      for (int r = 0; r < 3; r++) begin
         model_q.delete();
         n = 0; guard = 0;
         while (n < 21 && guard < 200) begin
            y_in = rand_beat(); y_valid = ($urandom_range(0, 3) != 0);
            if (y_valid) begin model_q.push_back(y_in); n++; end
            cyc(); guard++;
            checks++;
            if (cnt21 !== 5'(n)) begin
               errors++;
               $display("FAIL b2b_run%0d_cnt got %0d want %0d", r, cnt21, n);
            end
         end
         y_valid = 1'b0;
         checks++;
         if (sv21 !== 1'b1 || sig21 !== ref_sig()) begin
            errors++;
            $display("FAIL b2b_run%0d_sig got v=%b sig=%h want 1 %h", r, sv21, sig21, ref_sig());
         end
         sig_ready = 1'b1; start21 = (r < 2); cyc(); sig_ready = 1'b0; start21 = 1'b0;
         checks++;
         if (busy21 !== (r < 2) || sv21 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_run%0d_next got busy=%b v=%b want %b 0", r, busy21, sv21, r < 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mid_run_reset();
      test_c1_ones();
      test_c1_zero_hold();
      test_toggle_valid();
      test_start_in_run();
      test_flip();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
